trap_ctrl: RTL and testbench

- Initiator-side sequencer for the banked register file's supervisor interface.
- Decides when to switch between the user bank (bank=0) and the supervisor bank (bank=1).
- Drives the control-register write path (cr_wr) and the sR1 cause-write path (sr1_wr).
- Sits between the core's instruction-boundary logic and the register file:
  - takes interrupts and software traps on instruction boundaries;
  - stalls the core during entry and exit;
  - restores user mode on return-from-trap.

---
 rtl/trap_pkg.sv | 36 +++
 rtl/trap_prio_enc.sv | 19 +
 rtl/trap_ctrl.sv | 140 ++++++++++++++
 tb/tb_trap_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared CR field indices, FSM encoding and CR rewrite helpers for trap_ctrl
package trap_pkg;

  localparam int CR_IE   = 0;
  localparam int CR_PIE  = 1;
  localparam int CR_MODE = 2;

  localparam logic [7:0] CAUSE_TRAP_BASE = 8'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    SETTLE = 2'd2,
    EXIT   = 2'd3
  } state_t;

  function automatic logic [15:0] cr_enter(input logic [15:0] cr);
    logic [15:0] r;
    r          = cr;
    r[CR_PIE]  = cr[CR_IE];
    r[CR_IE]   = 1'b0;
    r[CR_MODE] = 1'b1;
    return r;
  endfunction

  // Return restores IE from PIE and consumes PIE, so a nested entry starts clean.
  function automatic logic [15:0] cr_exit(input logic [15:0] cr);
    logic [15:0] r;
    r          = cr;
    r[CR_IE]   = cr[CR_PIE];
    r[CR_PIE]  = 1'b0;
    r[CR_MODE] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - lowest-index-wins priority encoder for up to 8 request lines
module trap_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  always_comb begin
    idx = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - user/supervisor bank sequencer for traps, irqs and return-from-trap
// Optional: TRAP_CTRL_IRQ_EDGE_EN latches irq rising edges until acknowledged.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int          IRQ_N          = 4,
  parameter logic [7:0]  CAUSE_IRQ_BASE = 8'h10,
  parameter logic [15:0] CR_INIT        = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_N-1:0] irq,
  input  logic             trap_req,
  input  logic [3:0]       trap_code,
  input  logic             reti,
  input  logic             instr_done,
  input  logic [15:0]      cr_rd,
  output logic [15:0]      cr_wr,
  output logic [15:0]      sr1_wr,
  output logic             bank,
  output logic             stall,
  output logic [IRQ_N-1:0] irq_ack,
  output logic             dbl_fault
);

  state_t           state, next_state;
  logic [IRQ_N-1:0] irq_src;
  logic             irq_valid;
  logic [2:0]       irq_idx;
  logic [7:0]       cause_q, next_cause;
  logic [2:0]       idx_q;
  logic             is_irq_q, take_irq, set_dbl, ack_en;

`ifdef TRAP_CTRL_IRQ_EDGE_EN
  logic [IRQ_N-1:0] irq_q, pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= '0;
      pend  <= '0;
    end else begin
      irq_q <= irq;
      pend  <= (pend & ~irq_ack) | (irq & ~irq_q);
    end
  end

  assign irq_src = pend;
`else
  assign irq_src = irq;
`endif

  trap_prio_enc #(.N(IRQ_N)) u_prio (
    .req   (irq_src),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bank      <= 1'b0;
      cause_q   <= 8'h00;
      idx_q     <= 3'd0;
      is_irq_q  <= 1'b0;
      dbl_fault <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == ENTER) begin
        cause_q  <= next_cause;
        idx_q    <= irq_idx;
        is_irq_q <= take_irq;
        bank     <= 1'b1;
      end
      if (state == EXIT) bank <= 1'b0;
      if (set_dbl) dbl_fault <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    next_cause = cause_q;
    take_irq   = 1'b0;
    set_dbl    = 1'b0;
    stall      = 1'b0;
    sr1_wr     = 16'h0000;
    cr_wr      = cr_rd;
    ack_en     = 1'b0;
    case (state)
      IDLE: begin
        if (instr_done) begin
          if (reti && bank) begin
            next_state = EXIT;
          end else if (trap_req) begin
            if (bank) begin
              set_dbl = 1'b1;
            end else begin
              next_state = ENTER;
              next_cause = CAUSE_TRAP_BASE | {4'h0, trap_code};
            end
          end else if (irq_valid && cr_rd[CR_IE] && !bank) begin
            next_state = ENTER;
            take_irq   = 1'b1;
            next_cause = CAUSE_IRQ_BASE + {5'd0, irq_idx};
          end
        end
      end
      ENTER: begin
        next_state = SETTLE;
        stall      = 1'b1;
        sr1_wr     = {8'h00, cause_q};
        cr_wr      = cr_enter(cr_rd);
        ack_en     = is_irq_q;
      end
      SETTLE: begin
        next_state = IDLE;
        stall      = 1'b1;
      end
      EXIT: begin
        next_state = IDLE;
        stall      = 1'b1;
        cr_wr      = cr_exit(cr_rd);
      end
      default: next_state = IDLE;
    endcase
    if (reset) begin
      stall  = 1'b0;
      sr1_wr = 16'h0000;
      cr_wr  = CR_INIT;
      ack_en = 1'b0;
    end
  end

  always_comb begin
    irq_ack = '0;
    for (int i = 0; i < IRQ_N; i++) begin
      irq_ack[i] = ack_en && (idx_q == 3'(i));
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl; expected stall cycles queued, monitor pops
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        trap_req;
  logic [3:0]  trap_code;
  logic        reti;
  logic        instr_done;
  logic [15:0] cr_rd;
  logic [15:0] cr_wr;
  logic [15:0] sr1_wr;
  logic        bank;
  logic        stall;
  logic [3:0]  irq_ack;
  logic        dbl_fault;

  typedef struct packed {
    logic [15:0] sr1;
    logic [15:0] cr;
    logic [3:0]  ack;
    logic        bnk;
  } pkt_t;

  pkt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  trap_ctrl #(
    .IRQ_N          (4),
    .CAUSE_IRQ_BASE (8'h10),
    .CR_INIT        (16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .trap_req   (trap_req),
    .trap_code  (trap_code),
    .reti       (reti),
    .instr_done (instr_done),
    .cr_rd      (cr_rd),
    .cr_wr      (cr_wr),
    .sr1_wr     (sr1_wr),
    .bank       (bank),
    .stall      (stall),
    .irq_ack    (irq_ack),
    .dbl_fault  (dbl_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [15:0] s, input logic [15:0] c,
                              input logic [3:0] a, input logic b);
    pkt_t p;
    p.sr1 = s;
    p.cr  = c;
    p.ack = a;
    p.bnk = b;
    return p;
  endfunction

  // Every stall cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && stall) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_stall: sr1_wr=%h cr_wr=%h expected no stall", sr1_wr, cr_wr);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        check("sr1_wr", 32'(sr1_wr), 32'(e.sr1));
        check("cr_wr", 32'(cr_wr), 32'(e.cr));
        check("irq_ack", 32'(irq_ack), 32'(e.ack));
        check("bank_in_stall", 32'(bank), 32'(e.bnk));
      end
    end
  end

  task automatic boundary(input logic t, input logic [3:0] code, input logic r);
    @(negedge clk);
    #1;
    trap_req   = t;
    trap_code  = code;
    reti       = r;
    instr_done = 1'b1;
    @(negedge clk);
    #1;
    instr_done = 1'b0;
    trap_req   = 1'b0;
    reti       = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    irq        = 4'b0000;
    trap_req   = 1'b0;
    trap_code  = 4'h0;
    reti       = 1'b0;
    instr_done = 1'b0;
    cr_rd      = 16'h00F0;

    // 1. reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_cr_wr", 32'(cr_wr), 32'h0000);
    check("rst_bank", 32'(bank), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sr1", 32'(sr1_wr), 32'h0000);
    check("rst_ack", 32'(irq_ack), 32'd0);
    check("rst_dbl", 32'(dbl_fault), 32'd0);
    reset = 1'b0;

    // 2. irq entry, lowest index of 0110 wins
    cr_rd = 16'h0001;
    irq   = 4'b0110;
    exp_q.push_back(mk(16'h0011, 16'h0006, 4'b0010, 1'b1));
    exp_q.push_back(mk(16'h0000, 16'h0001, 4'b0000, 1'b1));
    boundary(1'b0, 4'h0, 1'b0);
    drain("irq_entry_drain");
    irq = 4'b0000;
    check("irq_entry_bank", 32'(bank), 32'd1);
    check("irq_entry_stall_done", 32'(stall), 32'd0);

    // 3. reti with simultaneous irq: reti wins, irq taken at next boundary
    cr_rd = 16'h0006;
    irq   = 4'b0001;
    exp_q.push_back(mk(16'h0000, 16'h0001, 4'b0000, 1'b1));
    boundary(1'b0, 4'h0, 1'b1);
    drain("reti_drain");
    check("reti_bank", 32'(bank), 32'd0);
    cr_rd = 16'h0001;
    exp_q.push_back(mk(16'h0010, 16'h0006, 4'b0001, 1'b1));
    exp_q.push_back(mk(16'h0000, 16'h0001, 4'b0000, 1'b1));
    boundary(1'b0, 4'h0, 1'b0);
    drain("irq0_drain");
    irq   = 4'b0000;
    cr_rd = 16'h0006;
    exp_q.push_back(mk(16'h0000, 16'h0001, 4'b0000, 1'b1));
    boundary(1'b0, 4'h0, 1'b1);
    drain("reti2_drain");
    check("reti2_bank", 32'(bank), 32'd0);

    // reti in user mode is ignored
    cr_rd = 16'h0000;
    boundary(1'b0, 4'h0, 1'b1);
    drain("user_reti_drain");
    check("user_reti_bank", 32'(bank), 32'd0);

    // 4. software trap with IE=0; held irq never taken
    irq = 4'b1000;
    exp_q.push_back(mk(16'h0025, 16'h0004, 4'b0000, 1'b1));
    exp_q.push_back(mk(16'h0000, 16'h0000, 4'b0000, 1'b1));
    boundary(1'b1, 4'h5, 1'b0);
    drain("trap5_drain");
    cr_rd = 16'h0004;
    exp_q.push_back(mk(16'h0000, 16'h0000, 4'b0000, 1'b1));
    boundary(1'b0, 4'h0, 1'b1);
    drain("trap5_exit_drain");
    cr_rd = 16'h0000;
    boundary(1'b0, 4'h0, 1'b0);
    drain("irq_masked_drain");
    check("irq_masked_bank", 32'(bank), 32'd0);
    irq = 4'b0000;

    // 5. double fault is sticky and causes no state change
    exp_q.push_back(mk(16'h0021, 16'h0004, 4'b0000, 1'b1));
    exp_q.push_back(mk(16'h0000, 16'h0000, 4'b0000, 1'b1));
    boundary(1'b1, 4'h1, 1'b0);
    drain("trap1_drain");
    cr_rd = 16'h0004;
    boundary(1'b1, 4'h2, 1'b0);
    drain("dbl_drain");
    check("dbl_set", 32'(dbl_fault), 32'd1);
    check("dbl_bank", 32'(bank), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("dbl_sticky", 32'(dbl_fault), 32'd1);
    exp_q.push_back(mk(16'h0000, 16'h0000, 4'b0000, 1'b1));
    boundary(1'b0, 4'h0, 1'b1);
    drain("dbl_exit_drain");
    check("dbl_exit_bank", 32'(bank), 32'd0);
    check("dbl_still", 32'(dbl_fault), 32'd1);

    // reset in the middle of ENTER
    cr_rd = 16'h0008;
    exp_q.push_back(mk(16'h0027, 16'h000C, 4'b0000, 1'b1));
    @(negedge clk);
    #1;
    trap_req   = 1'b1;
    trap_code  = 4'h7;
    instr_done = 1'b1;
    @(negedge clk);
    #1;
    instr_done = 1'b0;
    trap_req   = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_bank", 32'(bank), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_sr1", 32'(sr1_wr), 32'h0000);
    check("midrst_ack", 32'(irq_ack), 32'd0);
    check("midrst_cr_wr", 32'(cr_wr), 32'h0000);
    check("midrst_dbl", 32'(dbl_fault), 32'd0);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_after_stall", 32'(stall), 32'd0);

    // 6. single-cycle irq[3] pulse, boundary five cycles later
    cr_rd = 16'h0001;
`ifdef TRAP_CTRL_IRQ_EDGE_EN
    exp_q.push_back(mk(16'h0013, 16'h0006, 4'b1000, 1'b1));
    exp_q.push_back(mk(16'h0000, 16'h0001, 4'b0000, 1'b1));
`endif
    @(negedge clk);
    #1;
    irq = 4'b1000;
    @(negedge clk);
    #1;
    irq = 4'b0000;
    repeat (3) @(negedge clk);
    boundary(1'b0, 4'h0, 1'b0);
    drain("pulse_drain");
`ifdef TRAP_CTRL_IRQ_EDGE_EN
    check("pulse_bank", 32'(bank), 32'd1);
`else
    check("pulse_bank", 32'(bank), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
